// File: rtl/block_cipher_engine.sv
// block_cipher_engine
//   Iterative block cipher: one round per clock over NUM_WORDS words of WORD_W
//   bits. Each round is a per-word rotate, a one-word cyclic shift that folds
//   the round key into the wrapped word, and a key XOR. Decrypt runs the exact
//   inverse with the round keys in reverse order, which are recovered by first
//   running the forward schedule to k_{ROUNDS-1} and then stepping it backwards.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (ready only while idle)
//   mode                0 = encrypt, 1 = decrypt (sampled on accept)
//   key                 base key k0 (sampled on accept)
//   data_in             block, word i = data_in[i*WORD_W +: WORD_W]
//   out_valid/out_ready output handshake
//   data_out            block register, same word ordering as data_in
//   busy                high whenever not idle
module block_cipher_engine #(
   parameter  int WORD_W    = 64,
   parameter  int NUM_WORDS = 4,
   parameter  int ROUNDS    = 3,
   localparam int BLOCK_W   = WORD_W * NUM_WORDS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               mode,
   input  logic [WORD_W-1:0]  key,
   input  logic [BLOCK_W-1:0] data_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLOCK_W-1:0] data_out,
   output logic               busy
);

   localparam int CNT_W = $clog2(ROUNDS + 1);
   // Counter value on the final key-expansion cycle (unused when ROUNDS == 1).
   localparam int KEXP_LAST = (ROUNDS > 1) ? ROUNDS - 2 : 0;

   typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

   state_t                             state_q, state_d;
   logic [NUM_WORDS-1:0][WORD_W-1:0]   blk_q, blk_d;
   logic [WORD_W-1:0]                  key_q, key_d;
   logic                               mode_q, mode_d;
   logic [CNT_W-1:0]                   cnt_q, cnt_d;

   // ---------------- round datapath ----------------
   logic [NUM_WORDS-1:0][WORD_W-1:0] rot_l, enc_sh, enc_blk;
   logic [NUM_WORDS-1:0][WORD_W-1:0] dec_x, dec_sh, dec_blk;

   for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
      // encrypt: rotl1, shift up (key folded into the wrapped word), key XOR
      assign rot_l[i] = {blk_q[i][WORD_W-2:0], blk_q[i][WORD_W-1]};
      if (i == 0) begin : g_enc_wrap
         assign enc_sh[i] = rot_l[NUM_WORDS-1] ^ key_q;
      end else begin : g_enc_shift
         assign enc_sh[i] = rot_l[i-1];
      end
      assign enc_blk[i] = enc_sh[i] ^ key_q;

      // decrypt: key XOR, shift down (unfold key from wrapped word), rotr1
      assign dec_x[i] = blk_q[i] ^ key_q;
      if (i == NUM_WORDS - 1) begin : g_dec_wrap
         assign dec_sh[i] = dec_x[0] ^ key_q;
      end else begin : g_dec_shift
         assign dec_sh[i] = dec_x[i+1];
      end
      assign dec_blk[i] = {dec_sh[i][0], dec_sh[i][WORD_W-1:1]};
   end

   // ---------------- key schedule ----------------
   logic [CNT_W-1:0]  cnt_m1;
   logic [WORD_W-1:0] key_fwd, key_bwd_x, key_bwd;

   assign cnt_m1    = cnt_q - CNT_W'(1);
   assign key_fwd   = {key_q[WORD_W-4:0], key_q[WORD_W-1:WORD_W-3]} ^ WORD_W'(cnt_q);
   assign key_bwd_x = key_q ^ WORD_W'(cnt_m1);
   assign key_bwd   = {key_bwd_x[2:0], key_bwd_x[WORD_W-1:3]};

   // ---------------- control ----------------
   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      key_d   = key_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               blk_d   = data_in;
               key_d   = key;
               mode_d  = mode;
               cnt_d   = '0;
               state_d = (!mode || ROUNDS == 1) ? ROUND : KEYEXP;
            end
         end
         KEYEXP: begin
            // walk forward to k_{ROUNDS-1}; decrypt consumes keys top-down
            key_d = key_fwd;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(KEXP_LAST)) state_d = ROUND;
         end
         ROUND: begin
            if (!mode_q) begin
               blk_d = enc_blk;
               key_d = key_fwd;
               if (cnt_q == CNT_W'(ROUNDS - 1)) state_d = DONE;
               else                             cnt_d = cnt_q + CNT_W'(1);
            end else begin
               blk_d = dec_blk;
               if (cnt_q != '0) begin
                  key_d = key_bwd;
                  cnt_d = cnt_m1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         blk_q   <= '0;
         key_q   <= '0;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         key_q   <= key_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign data_out  = blk_q;

endmodule

// File: doc/block_cipher_engine.md
# block_cipher_engine

- Iterative, parametrised block-cipher core that encrypts or decrypts one block per transaction.
- Each round applies the team's bit-rotate / word-shift / key-XOR transform to all words.
- The round count, word width, word count and direction are selectable, and the round keys come from an on-chip reversible key schedule.
- It sits between a padding front end and the output sink, with valid/ready handshakes on both sides.

## Interface
- WORD_W, 64, bits per word and key width; WORD_W ≥ 8.
- NUM_WORDS, 4, words per block; ≥ 2. BLOCK_W = WORD_W*NUM_WORDS.
- ROUNDS, 3, rounds per block; ≥ 1.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  block/key/mode offered.
- in_ready  output  1  engine can accept; high only in IDLE.
- mode  input  1  0 = encrypt, 1 = decrypt; sampled on accept.
- key  input  WORD_W  base key k0; sampled on accept.
- data_in  input  BLOCK_W  word i = data_in[i*WORD_W +: WORD_W]; sampled on accept.
- out_valid  output  1  result available.
- out_ready  input  1  sink takes result.
- data_out  output  BLOCK_W  result block; same word ordering as data_in.
- busy  output  1  high in KEYEXP, ROUND or DONE.

## Operation
- Notation:
  - w_i = word i of the block register; N = NUM_WORDS.
  - rotlK / rotrK = rotate within WORD_W bits.
  - r = round index, zero-extended to WORD_W.
- Key schedule: k_{r+1} = rotl3(k_r) ^ r. Inverse: k_{r-1} = rotr3(k_r ^ (r-1)).
- Encrypt round with key k, steps in order:
  - (1) w_i = rotl1(w_i) for all i.
  - (2) shift up: w_{i+1} ← w_i for i < N-1, and w_0 ← w_{N-1} ^ k.
  - (3) w_i ^= k for all i.
- Decrypt round (exact inverse):
  - (1) w_i ^= k.
  - (2) shift down: w_i ← w_{i+1} for i < N-1, and w_{N-1} ← w_0 ^ k.
  - (3) w_i = rotr1(w_i).
- Encryption uses k_0 … k_{ROUNDS-1} in ascending order. Decryption uses them in descending order.
- FSM states: IDLE, KEYEXP, ROUND, DONE.
- IDLE:
  - Accept when in_valid && in_ready: load block register, key register ← key, mode register, round counter ← 0.
  - Next state is ROUND if encrypt or ROUNDS = 1; otherwise KEYEXP.
- KEYEXP (decrypt only):
  - Runs ROUNDS-1 cycles; each cycle key_reg ← rotl3(key_reg) ^ cnt, cnt++.
  - Exits to ROUND holding k_{ROUNDS-1}, with cnt = ROUNDS-1.
- ROUND, one round per cycle:
  - Encrypt: use key_reg, then key_reg ← rotl3(key_reg) ^ cnt, cnt++.
  - Decrypt: use key_reg, then, if cnt > 0, key_reg ← rotr3(key_reg ^ (cnt-1)), cnt--.
  - Go to DONE after ROUNDS rounds.
- DONE:
  - out_valid = 1 and data_out is held stable.
  - On out_ready go to IDLE; out_valid drops the next cycle.
- Inputs presented outside IDLE are ignored and never queued; in_valid is a don't-care while busy.
- data_out always reflects the block register. It is meaningful only while out_valid = 1.

## Timing
- Reset values (asynchronous):
  - state = IDLE, cnt = 0, block/key/mode registers = 0.
  - out_valid = 0, data_out = 0, busy = 0, in_ready = 1.
- in_ready and out_valid decode combinationally from state, so there is no extra register stage.
- Encrypt latency: out_valid rises exactly ROUNDS cycles after the accept edge.
- Decrypt latency: 2*ROUNDS-1 cycles after the accept edge.
- With out_ready held high, DONE lasts 1 cycle and the next accept can occur 1 cycle later. Minimum encrypt spacing is ROUNDS+2 cycles.
- Back-pressure: DONE persists indefinitely with data_out unchanged until out_ready = 1.
- Reset asserted mid-KEYEXP/ROUND/DONE:
  - Immediate return to IDLE with all reset values.
  - The partial result is discarded and no out_valid pulse occurs.
- Counter width is clog2(ROUNDS+1). The counter never wraps: exit conditions are compared before increment/decrement.

## Test plan
- WORD_W=8, N=2, ROUNDS=1, encrypt, key 0x00, data 0x8001 -> data_out 0x0201, out_valid high 1 cycle after accept.
- Same parameters, encrypt, key 0xFF, data 0x8001 -> 0xFD01. Then decrypt 0xFD01 with key 0xFF -> 0x8001, also 1 cycle latency.
- Defaults (64/4/3):
  - Encrypt random block with key 0x0123456789ABCDEF -> out_valid at +3 cycles.
  - Decrypt that result -> original block, out_valid at +5 cycles.
  - Run 100 random round-trips.
- Back-pressure:
  - Hold out_ready = 0 for 10 cycles in DONE -> data_out constant, in_ready = 0.
  - A second in_valid during this window is ignored.
  - out_ready = 1 -> IDLE the next cycle.
- Assert rst_n low during the second ROUND cycle -> all outputs at reset values immediately, in_ready = 1, no out_valid afterwards. A new block then completes normally.
